// File: rtl/ln_var_eps_fp16_if.sv
// Stream interface for the LayerNorm statistics stage: sample input with
// flush, and the registered result (FP16 var+eps, mean) with its 1-cycle pulse.
interface ln_var_eps_fp16_if #(
   parameter int DATA_W = 16
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic [15:0]       out_fp16;
   logic [DATA_W-1:0] mean_out;

   modport master (
      output flush, in_valid, in_data,
      input  in_ready, out_valid, out_fp16, mean_out
   );

   modport slave (
      input  flush, in_valid, in_data,
      output in_ready, out_valid, out_fp16, mean_out
   );
endinterface

// File: rtl/ln_var_eps_fp16.sv
// LayerNorm statistics: accumulates N signed fixed-point samples, computes the
// floor mean and (E[x^2] - mean^2) + EPS, converts the latter to FP16
// (flush-to-zero, saturate to max finite) and pulses out_valid for one cycle.
module ln_var_eps_fp16 #(
   parameter int              DATA_W = 16,
   parameter int              FRAC_W = 8,
   parameter int              LOG2_N = 2,
   parameter longint unsigned EPS    = 7
) (
   input logic               clk,
   input logic               rst_n,
   ln_var_eps_fp16_if.slave  bus
);
   localparam int SUM_W = DATA_W + LOG2_N;
   localparam int SQ_W  = 2 * DATA_W + LOG2_N;
   localparam int VAR_W = 2 * DATA_W;
   localparam int IDX_W = $clog2(VAR_W);
   localparam logic [LOG2_N-1:0] LAST_CNT = '1;

   typedef enum logic [1:0] {
      S_ACCUM = 2'd0,
      S_CALC  = 2'd1,
      S_CONV  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                   state_q;
   logic [LOG2_N-1:0]        count_q;
   logic signed [SUM_W-1:0]  sum_q;
   logic [SQ_W-1:0]          sumsq_q;
   logic [VAR_W-1:0]         var_eps_q;
   logic [DATA_W-1:0]        mean_q;
   logic [15:0]              fp16_q;
   logic                     out_valid_q;

   // Datapath next values (combinational)
   logic signed [DATA_W-1:0] sample;
   logic signed [VAR_W-1:0]  sq_s;
   logic signed [SUM_W-1:0]  mean_full;
   logic [DATA_W-1:0]        mean_d;
   logic signed [VAR_W-1:0]  mean_sq;
   logic [VAR_W-1:0]         ex2;
   logic signed [VAR_W:0]    diff;
   logic [VAR_W-1:0]         var_v;
   logic [VAR_W:0]           var_sum;
   logic [VAR_W-1:0]         var_eps_d;
   logic [IDX_W-1:0]         msb_idx;
   logic [IDX_W-1:0]         norm_sh;
   logic [VAR_W-1:0]         norm;
   logic [9:0]               mant;
   int                       exp_v;
   logic [4:0]               exp5;
   logic [15:0]              fp16_d;

   assign bus.in_ready  = (state_q == S_ACCUM);
   assign bus.out_valid = out_valid_q;
   assign bus.out_fp16  = fp16_q;
   assign bus.mean_out  = mean_q;

   // Square of the incoming sample and mean / variance+eps from the accumulators
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      sample    = signed'(bus.in_data);
      sq_s      = sample * sample;
      mean_full = sum_q >>> LOG2_N;
      mean_d    = mean_full[DATA_W-1:0];
      mean_sq   = signed'(mean_d) * signed'(mean_d);
      ex2       = sumsq_q[SQ_W-1:LOG2_N];
      diff      = signed'({1'b0, ex2}) - signed'({1'b0, mean_sq});
      var_v     = diff[VAR_W] ? '0 : diff[VAR_W-1:0];
      var_sum   = {1'b0, var_v} + (VAR_W+1)'(EPS);
      var_eps_d = var_sum[VAR_W] ? '1 : var_sum[VAR_W-1:0];
   end

   // FP16 conversion of the registered var+eps: normalise on the leading one, truncate
   always_comb begin
      msb_idx = '0;
      for (int i = 0; i < VAR_W; i++) begin
         if (var_eps_q[i]) msb_idx = IDX_W'(i);
      end
      norm_sh = IDX_W'(VAR_W - 1) - msb_idx;
      norm    = var_eps_q << norm_sh;
      mant    = norm[VAR_W-2 -: 10];
      exp_v   = int'(msb_idx) - 2 * FRAC_W + 15;
      exp5    = exp_v[4:0];
      if (var_eps_q == '0 || exp_v < 1) begin
         fp16_d = 16'h0000;
      end else if (exp_v > 30) begin
         fp16_d = 16'h7BFF;
      end else begin
         fp16_d = {1'b0, exp5, mant};
      end
   end

   // Control FSM with accumulators and registered result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
         state_q     <= S_ACCUM;
         count_q     <= '0;
         sum_q       <= '0;
         sumsq_q     <= '0;
         var_eps_q   <= '0;
         mean_q      <= '0;
         fp16_q      <= '0;
         out_valid_q <= 1'b0;
      end else if (bus.flush) begin
         // Abort wins over any accepted sample; results stay visible.
         state_q     <= S_ACCUM;
         count_q     <= '0;
         sum_q       <= '0;
         sumsq_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_ACCUM: begin
               out_valid_q <= 1'b0;
               if (bus.in_valid) begin
                  sum_q   <= sum_q + SUM_W'(sample);
                  sumsq_q <= sumsq_q + SQ_W'(unsigned'(sq_s));
                  if (count_q == LAST_CNT) begin
                     count_q <= '0;
                     state_q <= S_CALC;
                  end else begin
                     count_q <= count_q + 1'b1;
                  end
               end
            end
            S_CALC: begin
               mean_q    <= mean_d;
               var_eps_q <= var_eps_d;
               sum_q     <= '0;
               sumsq_q   <= '0;
               state_q   <= S_CONV;
            end
            S_CONV: begin
               fp16_q      <= fp16_d;
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= S_ACCUM;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ln_var_eps_fp16.sv
// Scoreboard bench for ln_var_eps_fp16: DUT A uses EPS=7, DUT B uses EPS=0.
// Stimulus pushes hand-computed results; monitors pop and compare on each pulse.
module tb_ln_var_eps_fp16;
   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   failures;

   typedef struct {
      logic [15:0] fp16;
      logic [15:0] mean;
      int          cyc;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   ln_var_eps_fp16_if #(.DATA_W(16)) bus_a ();
   ln_var_eps_fp16_if #(.DATA_W(16)) bus_b ();

   ln_var_eps_fp16 #(.DATA_W(16), .FRAC_W(8), .LOG2_N(2), .EPS(7)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   ln_var_eps_fp16 #(.DATA_W(16), .FRAC_W(8), .LOG2_N(2), .EPS(0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor for DUT A
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus_a.out_valid === 1'b1) begin
            if (q_a.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pulse_a: got pulse at cycle %0d expected none", cyc);
            end else begin
               e = q_a.pop_front();
               check("fp16_a", 32'(bus_a.out_fp16), 32'(e.fp16));
               check("mean_a", 32'(bus_a.mean_out), 32'(e.mean));
               check("latency_a", cyc, e.cyc);
            end
         end
      end
   end

   // Monitor for DUT B
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus_b.out_valid === 1'b1) begin
            if (q_b.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pulse_b: got pulse at cycle %0d expected none", cyc);
            end else begin
               e = q_b.pop_front();
               check("fp16_b", 32'(bus_b.out_fp16), 32'(e.fp16));
               check("mean_b", 32'(bus_b.mean_out), 32'(e.mean));
               check("latency_b", cyc, e.cyc);
            end
         end
      end
   end

   // Present one sample (called at a negedge); returns the accept edge and stall count.
   task automatic send(input bit sel, input logic [15:0] d, output int acc, output int stalls);
      int guard;
      stalls = 0;
      guard  = 0;
      if (sel) begin
         bus_b.in_valid = 1'b1;
         bus_b.in_data  = d;
      end else begin
         bus_a.in_valid = 1'b1;
         bus_a.in_data  = d;
      end
      while (!(sel ? bus_b.in_ready : bus_a.in_ready) && guard < 20) begin
         @(negedge clk);
         stalls++;
         guard++;
      end
      if (guard >= 20) begin
         checks++;
         failures++;
         $display("FAIL in_ready_timeout: got no in_ready after %0d cycles expected at most 19", guard);
      end
      acc = cyc + 1;
      @(negedge clk);
   endtask

   // Send a full vector, queue its expected result, optionally check the inter-vector stall.
   task automatic send_vec(input bit sel, input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [15:0] d3,
                           input logic [15:0] exp_fp16, input logic [15:0] exp_mean,
                           input bit chk_stall);
      int   acc;
      int   st;
      exp_t e;
      send(sel, d0, acc, st);
      if (chk_stall) check("stall_cycles", st, 3);
      send(sel, d1, acc, st);
      send(sel, d2, acc, st);
      send(sel, d3, acc, st);
      e.fp16 = exp_fp16;
      e.mean = exp_mean;
      e.cyc  = acc + 2;
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
   endtask

   task automatic idle(input int n);
      bus_a.in_valid = 1'b0;
      bus_b.in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int st;
      cyc            = 0;
      checks         = 0;
      failures       = 0;
      rst_n          = 1'b0;
      bus_a.flush    = 1'b0;
      bus_a.in_valid = 1'b0;
      bus_a.in_data  = '0;
      bus_b.flush    = 1'b0;
      bus_b.in_valid = 1'b0;
      bus_b.in_data  = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(bus_a.in_ready), 1);
      check("rst_out_valid", 32'(bus_a.out_valid), 0);
      check("rst_out_fp16", 32'(bus_a.out_fp16), 0);
      check("rst_mean_out", 32'(bus_a.mean_out), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Test 1: constant 1.0 -> var=0, var+eps=7 -> smallest normal exponent
      send_vec(1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0700, 16'h0100, 1'b0);
      idle(6);

      // Back-to-back with in_valid held high: tests 2, 3, negative-var clamp, extreme range
      send_vec(1'b0, 16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 16'h3C00, 16'h0000, 1'b0);
      send_vec(1'b0, 16'h0200, 16'h0000, 16'h0200, 16'h0000, 16'h3C00, 16'h0100, 1'b1);
      send_vec(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0700, 16'hFFFF, 1'b1);
      send_vec(1'b0, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h73FF, 16'hFFFF, 1'b1);
      idle(6);

      // EPS=0: zero flush, exponent below 1, exact 1.0
      send_vec(1'b1, 16'h0300, 16'h0300, 16'h0300, 16'h0300, 16'h0000, 16'h0300, 1'b0);
      send_vec(1'b1, 16'h0000, 16'h0000, 16'h0002, 16'h0002, 16'h0000, 16'h0001, 1'b1);
      send_vec(1'b1, 16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 16'h3C00, 16'h0000, 1'b1);
      idle(6);

      // Test 5: partial vector aborted by flush with a simultaneous valid sample
      send(1'b0, 16'h0500, acc, st);
      send(1'b0, 16'h0700, acc, st);
      bus_a.flush    = 1'b1;
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 16'h7FFF;
      @(negedge clk);
      bus_a.flush    = 1'b0;
      bus_a.in_valid = 1'b0;
      check("flush_in_ready", 32'(bus_a.in_ready), 1);
      check("flush_keeps_fp16", 32'(bus_a.out_fp16), 32'h73FF);
      send_vec(1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0700, 16'h0100, 1'b0);
      idle(6);

      // Asynchronous reset mid-vector clears results and discards the partial vector
      send(1'b0, 16'h1234, acc, st);
      send(1'b0, 16'h0F00, acc, st);
      bus_a.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_fp16", 32'(bus_a.out_fp16), 0);
      check("midrst_mean_out", 32'(bus_a.mean_out), 0);
      check("midrst_in_ready", 32'(bus_a.in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_vec(1'b0, 16'h0200, 16'h0000, 16'h0200, 16'h0000, 16'h3C00, 16'h0100, 1'b0);
      idle(10);

      check("queue_a_empty", q_a.size(), 0);
      check("queue_b_empty", q_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
